// File: rtl/kamus_lsu_ctrl.sv
// rtl/kamus_lsu_ctrl.sv - load/store sequencer between the MEM stage and the L1D port
module kamus_lsu_ctrl #(
   parameter int TIMEOUT_CYC = 64,
   parameter int XLEN        = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            mem_valid_i,
   input  logic            mem_we_i,
   input  logic [1:0]      mem_size_i,
   input  logic            mem_unsigned_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misaligned_o,
   output logic            bus_err_o,
   output logic            l1d_req_o,
   output logic            l1d_we_o,
   output logic [XLEN-1:0] l1d_addr_o,
   output logic [3:0]      l1d_be_o,
   output logic [XLEN-1:0] l1d_wdata_o,
   input  logic            l1d_gnt_i,
   input  logic            l1d_rvalid_i,
   input  logic [XLEN-1:0] l1d_rdata_i
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t          state, state_nxt;
   logic            we_q, uns_q, mis_q, err_q;
   logic [1:0]      size_q;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [7:0]      cnt_q;

   logic            accept, mis_in, tmo_hit, set_err;
   logic [3:0]      be_c;
   logic [XLEN-1:0] wdata_c, shifted, aligned;

   assign accept  = mem_valid_i & ~flush_i;
   assign mis_in  = (mem_size_i == 2'b01 & mem_addr_i[0]) |
                    (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00));
   assign tmo_hit = (cnt_q == TMO_LAST);

   always_comb begin
      state_nxt = state;
      set_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = mis_in ? DONE : REQ;
         end
         REQ: begin
            if (l1d_gnt_i) begin
               if (flush_i) state_nxt = we_q ? IDLE : DRAIN;
               else         state_nxt = we_q ? DONE : WAIT;
            end else if (flush_i) begin
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               state_nxt = DONE;
               set_err   = 1'b1;
            end
         end
         WAIT: begin
            // Data that arrives with the flush belongs to the killed instruction.
            if (l1d_rvalid_i) begin
               state_nxt = flush_i ? IDLE : DONE;
            end else if (flush_i) begin
               state_nxt = DRAIN;
            end else if (tmo_hit) begin
               state_nxt = DONE;
               set_err   = 1'b1;
            end
         end
         DRAIN: begin
            if (l1d_rvalid_i) state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = wdata_q;
      unique case (size_q)
         2'b00: begin
            be_c    = 4'b0001 << addr_q[1:0];
            wdata_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata_q[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = wdata_q;
         end
      endcase
   end

   assign shifted = l1d_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      aligned = shifted;
      unique case (size_q)
         2'b00:   aligned = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   aligned = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: aligned = shifted;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept) begin
            we_q    <= mem_we_i;
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            mis_q   <= mis_in;
            err_q   <= 1'b0;
         end
         if (set_err) err_q <= 1'b1;
         if (state_nxt == REQ && state != REQ) begin
            cnt_q <= 8'd0;
         end else if (state == REQ || state == WAIT) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (state == WAIT && l1d_rvalid_i && !flush_i) rdata_q <= aligned;
      end
   end

   assign stall_o      = accept & (state != DONE) & (state != DRAIN);
   assign done_o       = (state == DONE);
   assign misaligned_o = done_o & mis_q;
   assign bus_err_o    = done_o & err_q;
   assign rdata_o      = rdata_q;

   assign l1d_req_o   = (state == REQ);
   assign l1d_we_o    = l1d_req_o & we_q;
   assign l1d_addr_o  = l1d_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign l1d_be_o    = l1d_req_o ? be_c : 4'b0000;
   assign l1d_wdata_o = l1d_req_o ? wdata_c : '0;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// tb/tb_kamus_lsu_ctrl.sv - scoreboard bench for kamus_lsu_ctrl
module tb_kamus_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0, mem_we = 1'b0, mem_uns = 1'b0, flush = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic        stall, done, mis, berr;
   logic [31:0] rdata;
   logic        req, l1_we, gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] l1_addr, l1_wdata, l1_rdata = '0;
   logic [3:0]  l1_be;

   kamus_lsu_ctrl #(.TIMEOUT_CYC(8), .XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_size_i(mem_size),
      .mem_unsigned_i(mem_uns), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .flush_i(flush), .stall_o(stall), .done_o(done), .rdata_o(rdata),
      .misaligned_o(mis), .bus_err_o(berr),
      .l1d_req_o(req), .l1d_we_o(l1_we), .l1d_addr_o(l1_addr), .l1d_be_o(l1_be),
      .l1d_wdata_o(l1_wdata), .l1d_gnt_i(gnt), .l1d_rvalid_i(rvalid), .l1d_rdata_i(l1_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {logic mis; logic err; logic ld; logic [31:0] rd; int cyc;} done_t;
   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} req_t;

   done_t done_q[$];
   req_t  req_q[$];
   int    nvec = 0, nerr = 0, cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            done_t e;
            e = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("misaligned", {31'd0, mis}, {31'd0, e.mis});
            chk("bus_err", {31'd0, berr}, {31'd0, e.err});
            if (e.ld && !e.mis && !e.err) chk("rdata", rdata, e.rd);
         end
      end
      if (rst_n && req && gnt) begin
         if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
         end else begin
            req_t r;
            r = req_q.pop_front();
            chk("l1d_we", {31'd0, l1_we}, {31'd0, r.we});
            chk("l1d_addr", l1_addr, r.addr);
            chk("l1d_be", {28'd0, l1_be}, {28'd0, r.be});
            chk("l1d_wdata", l1_wdata, r.wd);
         end
      end
   end

   // gdly < 0: grant never given. lat: cycle index of done_o counted from the valid cycle.
   task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rd, input int lat,
                        input logic emis, input logic eerr, input logic [31:0] erd,
                        input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
                        output int stalls);
      done_t e;
      req_t  r;
      bit    seen = 0;
      stalls = 0;
      @(posedge clk); #1;
      e.mis = emis; e.err = eerr; e.ld = ~we; e.rd = erd; e.cyc = cyc + lat;
      done_q.push_back(e);
      if (!emis && gdly >= 0) begin
         r.we = we; r.addr = eaddr; r.be = ebe; r.wd = ewd;
         req_q.push_back(r);
      end
      mem_valid = 1; mem_we = we; mem_size = sz; mem_uns = uns; mem_addr = addr; mem_wdata = wd;
      for (int n = 0; n < 40; n++) begin
         gnt      = (gdly >= 0) && (n == 1 + gdly);
         rvalid   = !we && (gdly >= 0) && (n == 1 + gdly + rdly);
         l1_rdata = rvalid ? rd : 32'h0;
         #3;
         if (stall) stalls++;
         if (done) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) chk("op_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      mem_valid = 0; gnt = 0; rvalid = 0;
   endtask

   int st;

   initial begin
      repeat (3) @(posedge clk);
      #4;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_be", {28'd0, l1_be}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;

      // SW 0x100
      do_op(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 2, 0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, st);
      chk("sw_stall_cycles", 32'(st), 32'd2);
      // LB / LBU 0x203
      do_op(0, 2'b00, 0, 32'h203, 0, 0, 2, 32'h80FF_0000, 4, 0, 0, 32'hFFFFFF80, 32'h200, 4'b1000, 0, st);
      do_op(0, 2'b00, 1, 32'h203, 0, 0, 2, 32'h80FF_0000, 4, 0, 0, 32'h00000080, 32'h200, 4'b1000, 0, st);
      // SH 0x12, LH 0x11 misaligned
      do_op(1, 2'b01, 0, 32'h12, 32'h0000ABCD, 0, 0, 0, 2, 0, 0, 0, 32'h10, 4'b1100, 32'hABCDABCD, st);
      do_op(0, 2'b01, 0, 32'h11, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, st);
      chk("lh_mis_stall_cycles", 32'(st), 32'd1);
      // LW with grant withheld: 8 REQ cycles then bus error, late rvalid ignored
      do_op(0, 2'b10, 0, 32'h30, 0, -1, 0, 0, 9, 0, 1, 0, 0, 0, 0, st);
      rvalid = 1; l1_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      rvalid = 0;
      // LH 0x22 with delayed grant, SB 0x01, size 11 as word, LW misaligned
      do_op(0, 2'b01, 0, 32'h22, 0, 2, 1, 32'h8001_1234, 5, 0, 0, 32'hFFFF8001, 32'h20, 4'b1100, 0, st);
      do_op(1, 2'b00, 0, 32'h01, 32'h0000005A, 1, 0, 0, 3, 0, 0, 0, 32'h0, 4'b0010, 32'h5A5A5A5A, st);
      do_op(1, 2'b11, 0, 32'h08, 32'h01234567, 0, 0, 0, 2, 0, 0, 0, 32'h8, 4'b1111, 32'h01234567, st);
      do_op(0, 2'b10, 0, 32'h102, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, st);

      // Flush in WAIT -> DRAIN; the drained response must not surface
      begin
         req_t r;
         r.we = 0; r.addr = 32'h40; r.be = 4'b1111; r.wd = 0;
         req_q.push_back(r);
      end
      @(posedge clk); #1;
      mem_valid = 1; mem_we = 0; mem_size = 2'b10; mem_uns = 0; mem_addr = 32'h40;
      @(posedge clk); #1; gnt = 1;
      @(posedge clk); #1; gnt = 0; flush = 1;
      @(posedge clk); #1; flush = 0;
      #3;
      chk("drain_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1; mem_valid = 0; rvalid = 1; l1_rdata = 32'hCAFECAFE;
      @(posedge clk); #1; rvalid = 0;
      do_op(0, 2'b10, 0, 32'h44, 0, 0, 1, 32'h12345678, 3, 0, 0, 32'h12345678, 32'h44, 4'b1111, 0, st);

      // Reset while in WAIT
      begin
         req_t r;
         r.we = 0; r.addr = 32'h80; r.be = 4'b1111; r.wd = 0;
         req_q.push_back(r);
      end
      @(posedge clk); #1;
      mem_valid = 1; mem_addr = 32'h80; mem_size = 2'b10; mem_we = 0;
      @(posedge clk); #1; gnt = 1;
      @(posedge clk); #1; gnt = 0; rst_n = 0; mem_valid = 0;
      @(posedge clk); #1;
      #3;
      chk("wrst_req", {31'd0, req}, 32'd0);
      chk("wrst_done", {31'd0, done}, 32'd0);
      chk("wrst_rdata", rdata, 32'd0);
      rst_n = 1; rvalid = 1; l1_rdata = 32'h55555555;
      @(posedge clk); #1; rvalid = 0;
      #3;
      chk("late_rv_done", {31'd0, done}, 32'd0);
      chk("late_rv_rdata", rdata, 32'd0);
      repeat (3) @(posedge clk);
      #3;
      chk("done_q_empty", 32'(done_q.size()), 32'd0);
      chk("req_q_empty", 32'(req_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
